// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing 16 x 8-bit registers: 2-flop sync + glitch filter on SCL/SDA, byte FSM, host read port.
// Define I2C_SLAVE_AUTOINC_EN for a pointer that advances after every byte; otherwise the pointer stays fixed.
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR = 7'h21,
    parameter int         FILT_LEN   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oen,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       wr_stb,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);
    localparam int CW = $clog2(FILT_LEN + 1);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_DEV_ADDR = 4'd1;
    localparam logic [3:0] S_DEV_ACK  = 4'd2;
    localparam logic [3:0] S_SUB_ADDR = 4'd3;
    localparam logic [3:0] S_SUB_ACK  = 4'd4;
    localparam logic [3:0] S_WR_DATA  = 4'd5;
    localparam logic [3:0] S_WR_ACK   = 4'd6;
    localparam logic [3:0] S_RD_DATA  = 4'd7;
    localparam logic [3:0] S_RD_ACK   = 4'd8;

`ifdef I2C_SLAVE_AUTOINC_EN
    localparam logic [3:0] PTR_STEP = 4'd1;
`else
    localparam logic [3:0] PTR_STEP = 4'd0;
`endif

    logic [1:0]    scl_sync, sda_sync;
    logic          scl_f, sda_f, scl_q, sda_q;
    logic [CW-1:0] scl_cnt, sda_cnt;

    // A level change is accepted only after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            scl_cnt  <= '0;
            sda_cnt  <= '0;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            scl_q    <= scl_f;
            sda_q    <= sda_f;
            if (scl_sync[1] == scl_f) begin
                scl_cnt <= '0;
            end else if (scl_cnt == CW'(FILT_LEN - 1)) begin
                scl_f   <= scl_sync[1];
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + 1'b1;
            end
            if (sda_sync[1] == sda_f) begin
                sda_cnt <= '0;
            end else if (sda_cnt == CW'(FILT_LEN - 1)) begin
                sda_f   <= sda_sync[1];
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + 1'b1;
            end
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_f & ~scl_q;
    assign scl_fall  = ~scl_f & scl_q;
    assign start_det = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;

    logic [3:0] state;
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic [6:0] tx;
    logic [3:0] ptr;
    logic       ack_ph;
    logic [7:0] regs [16];
    logic [7:0] rx_byte;
    logic [3:0] ptr_next;

    assign rx_byte  = {shreg, sda_f};
    assign ptr_next = ptr + PTR_STEP;
    assign rd_data  = regs[rd_addr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            sda_oen <= 1'b1;
            wr_stb  <= 1'b0;
            wr_addr <= 4'd0;
            wr_data <= 8'h00;
            busy    <= 1'b0;
            ptr     <= 4'd0;
            bit_cnt <= 3'd0;
            shreg   <= 7'd0;
            tx      <= 7'd0;
            ack_ph  <= 1'b0;
            for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
        end else begin
            wr_stb <= 1'b0;
            if (stop_det) begin
                state   <= S_IDLE;
                busy    <= 1'b0;
                sda_oen <= 1'b1;
                ack_ph  <= 1'b0;
            end else if (start_det) begin
                state   <= S_DEV_ADDR;
                bit_cnt <= 3'd0;
                sda_oen <= 1'b1;
                ack_ph  <= 1'b0;
            end else begin
                case (state)
                    S_DEV_ADDR, S_SUB_ADDR, S_WR_DATA: if (scl_rise) begin
                        shreg   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        ack_ph  <= 1'b0;
                        if (bit_cnt == 3'd7) begin
                            case (state)
                                S_DEV_ADDR: begin
                                    if (rx_byte[7:1] == SLAVE_ADDR) begin
                                        state <= S_DEV_ACK;
                                        busy  <= 1'b1;
                                    end else begin
                                        state <= S_IDLE;
                                        busy  <= 1'b0;
                                    end
                                end
                                S_SUB_ADDR: begin
                                    ptr   <= rx_byte[3:0];
                                    state <= S_SUB_ACK;
                                end
                                default: begin
                                    regs[ptr] <= rx_byte;
                                    wr_stb    <= 1'b1;
                                    wr_addr   <= ptr;
                                    wr_data   <= rx_byte;
                                    ptr       <= ptr_next;
                                    state     <= S_WR_ACK;
                                end
                            endcase
                        end
                    end
                    // First falling edge drives the ACK, the second ends the ACK period.
                    S_DEV_ACK, S_SUB_ACK, S_WR_ACK: if (scl_fall) begin
                        if (!ack_ph) begin
                            sda_oen <= 1'b0;
                            ack_ph  <= 1'b1;
                        end else begin
                            ack_ph  <= 1'b0;
                            bit_cnt <= 3'd0;
                            sda_oen <= 1'b1;
                            if (state != S_DEV_ACK) begin
                                state <= S_WR_DATA;
                            end else if (shreg[0]) begin
                                state   <= S_RD_DATA;
                                tx      <= regs[ptr][6:0];
                                sda_oen <= regs[ptr][7];
                            end else begin
                                state <= S_SUB_ADDR;
                            end
                        end
                    end
                    S_RD_DATA: begin
                        if (scl_fall) begin
                            tx      <= {tx[5:0], 1'b0};
                            sda_oen <= tx[6];
                        end else if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state  <= S_RD_ACK;
                                ack_ph <= 1'b0;
                                ptr    <= ptr_next;
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (scl_fall) begin
                            if (!ack_ph) begin
                                sda_oen <= 1'b1;
                                ack_ph  <= 1'b1;
                            end else begin
                                ack_ph  <= 1'b0;
                                bit_cnt <= 3'd0;
                                state   <= S_RD_DATA;
                                tx      <= regs[ptr][6:0];
                                sda_oen <= regs[ptr][7];
                            end
                        end else if (scl_rise && ack_ph && sda_f) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: busy <= 1'b0;
                endcase
            end
        end
    end
endmodule
